spi_wb_master: RTL and testbench
================================

# spi_wb_master

Upstream feeder of the channel FPGA's 16-bit Wishbone register blocks. It is an SPI slave: the controlling FPGA shifts 32-bit frames in, and this block turns each frame into one single-word Wishbone read or write cycle. Read data is returned on MISO within the same frame. All SPI inputs are oversampled in the `wb_clk` domain, so the block has one clock.

## Interface
Parameters:
- `ADRBITS`, default 15: Wishbone address width (1..15). Only the low `ADRBITS` bits of the frame address are used.
- `TMO`, default 15: ack timeout in `wb_clk` cycles, counted from `wb_stb` assertion.

Ports:
- `wb_clk` input 1: sole clock. Requirement: f(`wb_clk`) ≥ 8 × f(`spi_sck`).
- `wb_rst` input 1: reset. Asynchronous assert, active-low; deassertion synchronous to `wb_clk` (externally provided).
- `spi_sck` input 1: SPI clock, mode 0 (idle low, sample on rising edge, shift on falling edge).
- `spi_cs_n` input 1: frame select, active-low.
- `spi_mosi` input 1: serial data in, MSB first.
- `spi_miso` output 1: serial data out, MSB first; 0 when `spi_cs_n` is high.
- `wb_adr` output `ADRBITS`: cycle address.
- `wb_dat_o` output 16: write data.
- `wb_dat_i` input 16: read data.
- `wb_we` output 1: write enable.
- `wb_cyc` output 1: cycle.
- `wb_stb` output 1: strobe.
- `wb_ack` input 1: slave acknowledge.
- `err` output 1: sticky timeout flag; cleared at the start of the next frame (`spi_cs_n` falling).

## Operation
- **Input synchronisation:** `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-FF synchroniser. SCK rising and falling edges are detected on the synchronised copy.
- **Frame format:** 32 bits.
  - Bit 31 = W (1 = write, 0 = read).
  - Bits 30:16 = address.
  - Bits 15:0 = data. For a write, MOSI carries the data; for a read, MISO returns it.
- **Bit counter:** 6 bits. It is cleared on the synchronised `spi_cs_n` falling edge and increments on each sampled SCK rising edge. It saturates at 32.
- **FSM states:**
  - IDLE → HDR on CS falling.
  - HDR → RDREQ after the 16th rising edge if W=0; HDR → WRDATA if W=1.
  - WRDATA → WBWR after the 32nd rising edge.
  - RDREQ: asserts a read cycle. → RDDATA on ack or timeout.
  - RDDATA: data shifts out. → WAITCS after the 32nd rising edge.
  - WBWR: asserts a write cycle. → WAITCS on ack or timeout.
  - WAITCS → IDLE on CS rising.
- **Wishbone cycle:**
  - `wb_cyc`, `wb_stb`, `wb_adr`, `wb_we` and `wb_dat_o` are registered and asserted together.
  - All of them are held until the first cycle where `wb_ack` = 1; `wb_cyc`/`wb_stb` drop in the following cycle.
  - Exactly one cycle is issued per frame.
- **Read data:** latched from `wb_dat_i` in the cycle `wb_ack` is sampled.
  - It is loaded into the MISO shift register.
  - Bit 15 is driven after the first SCK falling edge following bit 16, then one bit per falling edge.
- **MISO during header:** 0.
- **Timeout:** if `wb_ack` is not seen within `TMO` cycles of `wb_stb`:
  - `wb_cyc`/`wb_stb` drop;
  - `err` is set;
  - on a read, 16'hFFFF is returned.
- **CS rising before bit 32:** aborts the frame.
  - A write cycle is never started.
  - A read cycle already in progress is completed (or times out), then the FSM goes to IDLE.
  - A new CS falling edge is ignored until the FSM is back in IDLE.
- **Extra SCK edges:** edges after bit 32 are ignored; MISO stays at the last data bit.
- **Reset values:** `wb_cyc`, `wb_stb`, `wb_we` = 0; `wb_adr` = 0; `wb_dat_o` = 0; `spi_miso` = 0; `err` = 0; FSM = IDLE; all shift registers and counters = 0.

## Timing
- SPI input to internal use: 2 cycles (synchroniser) + 1 cycle (edge detect).
- Write:
  - `wb_stb` asserts 1 cycle after the detected 32nd rising edge.
  - With a 1-cycle-ack slave, the cycle ends 2 cycles later.
- Read:
  - `wb_stb` asserts 1 cycle after the detected 16th rising edge.
  - Data must be in the shift register before the next detected falling edge. At 8× oversampling this leaves ≥ 1 cycles of margin for a 1-cycle-ack slave.
  - A slower slave requires a lower SCK or extra host delay.
- `err` sets in the cycle after the timeout expires.
- A reset assertion mid-cycle drops `wb_cyc`/`wb_stb` immediately (asynchronously).

## Configuration
- Macro: `SPI_WB_TIMEOUT_EN`.
- Defined: the timeout counter is implemented as described above.
- Undefined:
  - The counter is absent and the block waits for `wb_ack` indefinitely.
  - `err` is tied to 0.
  - `TMO` is ignored.

## Test plan
- **Write:** frame 0x8005_1234 with a parreg16-style slave → one cycle with `wb_adr`=5, `wb_dat_o`=0x1234, `wb_we`=1; `wb_cyc` high for exactly 2 cycles; `err`=0.
- **Read:** register 5 holds 0xBEEF; frame 0x0005_xxxx → read cycle at `wb_adr`=5, `wb_we`=0; MISO bits 15..0 = 0xBEEF.
- **Timeout:** slave never acks, read frame to address 3 → `wb_stb` drops after 15 cycles; `err`=1; MISO returns 0xFFFF; the next frame's CS falling edge clears `err`.
- **Abort:** CS rises after 20 bits of a write frame → no Wishbone cycle is issued. The following full write frame works normally.
- **Reset:** `wb_rst` low while `wb_stb`=1 → `wb_cyc`, `wb_stb`, `spi_miso` = 0 immediately. After release, a write of 0x0001 to address 0 succeeds.
- **Back-to-back:** two write frames separated by 4 SCK periods of CS high → two cycles with the correct addresses and data, in order.

Source files
------------

// File: rtl/spi_wb_master.sv
// SPI slave (mode 0, 32-bit frames) that issues one 16-bit Wishbone read or write per frame.
// Optional ack timeout and sticky err flag are built when SPI_WB_TIMEOUT_EN is defined.
module spi_wb_master #(
  parameter int ADRBITS = 15,
  parameter int TMO     = 15
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               spi_sck,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic [ADRBITS-1:0] wb_adr,
  output logic [15:0]        wb_dat_o,
  input  logic [15:0]        wb_dat_i,
  output logic               wb_we,
  output logic               wb_cyc,
  output logic               wb_stb,
  input  logic               wb_ack,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, HDR, WRDATA, RDREQ, RDDATA, WBWR, WAITCS} state_t;

  state_t       state, state_nxt;
  logic [2:0]   sck_sync, cs_sync;
  logic [1:0]   mosi_sync;
  logic [5:0]   bit_cnt;
  logic [29:0]  shift_in;
  logic [15:0]  miso_sr;
  logic         miso_q;

  logic         sck_rise, sck_fall, cs_fall, cs_on, mosi_s;
  logic         bit_rise, hdr_done, frame_done, rd_go, wr_go, wb_end, tmo_hit;
  logic [14:0]  hdr_adr;

  // Synchronisers: index 1 is the usable copy, index 2 the one-cycle-old copy for edge detection
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi_sck};
      cs_sync   <= {cs_sync[1:0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  assign sck_rise   = sck_sync[1] & ~sck_sync[2];
  assign sck_fall   = ~sck_sync[1] & sck_sync[2];
  assign cs_fall    = ~cs_sync[1] & cs_sync[2];
  assign cs_on      = ~cs_sync[1];
  assign mosi_s     = mosi_sync[1];

  assign bit_rise   = sck_rise & cs_on & (bit_cnt != 6'd32);
  assign hdr_adr    = {shift_in[13:0], mosi_s};
  assign hdr_done   = (state == HDR) & bit_rise & (bit_cnt == 6'd15);
  assign frame_done = bit_rise & (bit_cnt == 6'd31);
  // At the 16th edge the write flag sits in shift_in[14]; at the 32nd the header sits in [29:15]
  assign rd_go      = hdr_done & ~shift_in[14];
  assign wr_go      = (state == WRDATA) & frame_done;
  assign wb_end     = wb_stb & (wb_ack | tmo_hit);

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = HDR;
      HDR:     if (!cs_on) state_nxt = IDLE;
               else if (hdr_done) state_nxt = shift_in[14] ? WRDATA : RDREQ;
      WRDATA:  if (!cs_on) state_nxt = IDLE;
               else if (frame_done) state_nxt = WBWR;
      RDREQ:   if (wb_end) state_nxt = RDDATA;
      RDDATA:  if (!cs_on) state_nxt = IDLE;
               else if (frame_done) state_nxt = WAITCS;
      WBWR:    if (wb_end) state_nxt = WAITCS;
      WAITCS:  if (!cs_on) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      bit_cnt  <= '0;
      shift_in <= '0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_dat_o <= '0;
      miso_sr  <= '0;
      miso_q   <= 1'b0;
    end else begin
      if ((state == IDLE) && cs_fall) bit_cnt <= '0;
      else if (bit_rise)              bit_cnt <= bit_cnt + 6'd1;

      if (bit_rise) shift_in <= {shift_in[28:0], mosi_s};

      if (rd_go) begin
        wb_cyc <= 1'b1;
        wb_stb <= 1'b1;
        wb_we  <= 1'b0;
        wb_adr <= hdr_adr[ADRBITS-1:0];
      end else if (wr_go) begin
        wb_cyc   <= 1'b1;
        wb_stb   <= 1'b1;
        wb_we    <= 1'b1;
        wb_adr   <= shift_in[15 +: ADRBITS];
        wb_dat_o <= {shift_in[14:0], mosi_s};
      end else if (wb_end) begin
        wb_cyc <= 1'b0;
        wb_stb <= 1'b0;
      end

      // A timed-out read returns all ones so the host can tell it from real data
      if ((state == RDREQ) && wb_end) begin
        miso_sr <= wb_ack ? wb_dat_i : 16'hFFFF;
      end else if ((state == RDDATA) && sck_fall && cs_on) begin
        miso_q  <= miso_sr[15];
        miso_sr <= {miso_sr[14:0], 1'b0};
      end

      if (state == IDLE) miso_q <= 1'b0;
    end
  end

  assign spi_miso = miso_q & ~spi_cs_n;

`ifdef SPI_WB_TIMEOUT_EN
  localparam int TW = (TMO < 2) ? 1 : $clog2(TMO);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign tmo_hit = wb_stb & ~wb_ack & (tmo_cnt == TW'(TMO - 1));
  assign err     = err_q;

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (rd_go || wr_go)         tmo_cnt <= '0;
      else if (wb_stb && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;

      if (tmo_hit)                          err_q <= 1'b1;
      else if ((state == IDLE) && cs_fall)  err_q <= 1'b0;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^TMO;
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_wb_master.sv
// Bench for spi_wb_master: SPI host model, registered 1-cycle-ack Wishbone slave, scoreboard of cycles.
module tb_spi_wb_master;

  localparam int HALF = 5;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [14:0] wb_adr;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_we, wb_cyc, wb_stb, err;
  logic        wb_ack = 1'b0;

  always #5 wb_clk = ~wb_clk;

  spi_wb_master #(.ADRBITS(15), .TMO(15)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .wb_adr   (wb_adr),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_we    (wb_we),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_ack   (wb_ack),
    .err      (err)
  );

  // Registered slave: acks after ack_delay extra cycles, never when no_ack is set
  logic [15:0] mem [32] = '{default: 16'h0000};
  logic        no_ack = 1'b0;
  int          ack_delay = 0;
  int          ack_wait = 0;

  assign wb_dat_i = mem[wb_adr[4:0]];

  always @(posedge wb_clk) begin
    wb_ack <= 1'b0;
    if (wb_cyc && wb_stb && !wb_ack && !no_ack) begin
      if (ack_wait < ack_delay) ack_wait <= ack_wait + 1;
      else begin
        wb_ack   <= 1'b1;
        ack_wait <= 0;
        if (wb_we) mem[wb_adr[4:0]] <= wb_dat_o;
      end
    end else begin
      ack_wait <= 0;
    end
  end

  typedef struct packed {
    logic        we;
    logic [14:0] adr;
    logic [15:0] dat;
  } xfer_t;

  typedef struct {
    logic        we;
    logic [14:0] adr;
    logic [15:0] dat;
    logic [15:0] exp;
  } vec_t;

  xfer_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    n_cyc = 0, cyc_run = 0, cyc_len = 0, stb_run = 0, stb_len = 0;
  logic  cyc_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge wb_clk) begin
    xfer_t e;
    if (wb_cyc && !cyc_prev) n_cyc++;
    cyc_prev = wb_cyc;
    if (wb_cyc) cyc_run++;
    else if (cyc_run != 0) begin cyc_len = cyc_run; cyc_run = 0; end
    if (wb_stb) stb_run++;
    else if (stb_run != 0) begin stb_len = stb_run; stb_run = 0; end
    if (wb_cyc && wb_stb && wb_ack) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_we", wb_we, e.we);
        chk("wb_adr", wb_adr, e.adr);
        if (e.we) chk("wb_dat_o", wb_dat_o, e.dat);
      end
    end
  end

  logic [15:0] rd;
  logic        hb;

  task automatic spi_xfer(input logic [31:0] f, input int hold16, input int gap, input int nbits,
                          output logic [15:0] rdat, output logic hdr_bad);
    rdat = '0;
    hdr_bad = 1'b0;
    @(negedge wb_clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge wb_clk);
    for (int i = 31; i > 31 - nbits; i--) begin
      spi_mosi = f[i];
      repeat (HALF) @(negedge wb_clk);
      if (i < 16) rdat[i] = spi_miso;
      else if (spi_miso !== 1'b0) hdr_bad = 1'b1;
      spi_sck = 1'b1;
      repeat (HALF + ((i == 16) ? hold16 : 0)) @(negedge wb_clk);
      spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge wb_clk);
    spi_cs_n = 1'b1;
    repeat (gap) @(negedge wb_clk);
  endtask

  task automatic do_write(input logic [14:0] a, input logic [15:0] d, input int gap);
    xfer_t e;
    logic [15:0] r;
    logic        h;
    e.we = 1'b1; e.adr = a; e.dat = d;
    sb.push_back(e);
    cyc_len = 0;
    spi_xfer({1'b1, a, d}, 4, gap, 32, r, h);
    chk("wr_cyc_len", cyc_len, 2);
    chk("wr_err", err, 0);
  endtask

  task automatic do_read(input logic [14:0] a, input logic [15:0] exp, input int hold);
    xfer_t e;
    logic [15:0] r;
    logic        h;
    e.we = 1'b0; e.adr = a; e.dat = 16'h0000;
    sb.push_back(e);
    spi_xfer({1'b0, a, 16'hC35A}, hold, 20, 32, r, h);
    chk("rd_miso", r, exp);
    chk("rd_hdr_miso", h, 0);
  endtask

  vec_t vt [10];
  int   n0;

  initial begin
    vt[0] = '{1'b1, 15'd5,      16'h1234, 16'h0000};
    vt[1] = '{1'b0, 15'd5,      16'h0000, 16'h1234};
    vt[2] = '{1'b1, 15'd5,      16'hBEEF, 16'h0000};
    vt[3] = '{1'b0, 15'd5,      16'h0000, 16'hBEEF};
    vt[4] = '{1'b1, 15'h7FFF,   16'hA5A5, 16'h0000};
    vt[5] = '{1'b0, 15'h7FFF,   16'h0000, 16'hA5A5};
    vt[6] = '{1'b1, 15'd2,      16'hFFFF, 16'h0000};
    vt[7] = '{1'b0, 15'd2,      16'h0000, 16'hFFFF};
    vt[8] = '{1'b0, 15'd0,      16'h0000, 16'h0000};
    vt[9] = '{1'b1, 15'h0010,   16'h8001, 16'h0000};

    #1 wb_rst = 1'b0;
    repeat (3) @(negedge wb_clk);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_dat_o", wb_dat_o, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_err", err, 0);
    wb_rst = 1'b1;
    repeat (5) @(negedge wb_clk);

    for (int k = 0; k < 10; k++) begin
      if (vt[k].we) do_write(vt[k].adr, vt[k].dat, 20);
      else          do_read(vt[k].adr, vt[k].exp, 4);
    end

    // Abort after 20 bits: no cycle, then a normal write and a read-back of the aborted address
    n0 = n_cyc;
    spi_xfer({1'b1, 15'd7, 16'h7777}, 0, 20, 20, rd, hb);
    chk("abort_no_cycle", n_cyc - n0, 0);
    do_write(15'd8, 16'h0808, 20);
    do_read(15'd7, 16'h0000, 4);
    do_read(15'd8, 16'h0808, 4);

    // Back-to-back writes with 4 SCK periods of CS high between them
    n0 = n_cyc;
    do_write(15'd3, 16'h1111, 40);
    do_write(15'd4, 16'h2222, 40);
    chk("b2b_cycles", n_cyc - n0, 2);

`ifdef SPI_WB_TIMEOUT_EN
    no_ack = 1'b1;
    stb_len = 0;
    n0 = n_cyc;
    spi_xfer({1'b0, 15'd3, 16'h0000}, 30, 20, 32, rd, hb);
    chk("tmo_stb_len", stb_len, 15);
    chk("tmo_err_set", err, 1);
    chk("tmo_miso", rd, 16'hFFFF);
    chk("tmo_cycles", n_cyc - n0, 1);
    no_ack = 1'b0;
    spi_cs_n = 1'b0;
    repeat (6) @(negedge wb_clk);
    chk("tmo_err_clear", err, 0);
    spi_cs_n = 1'b1;
    repeat (20) @(negedge wb_clk);
`else
    ack_delay = 6;
    stb_len = 0;
    do_read(15'd5, 16'hBEEF, 30);
    chk("slow_stb_len", stb_len, 8);
    chk("slow_err", err, 0);
    ack_delay = 0;
`endif

    // Reset while the strobe is up drops the cycle at once
    ack_delay = 4;
    fork
      spi_xfer({1'b1, 15'd9, 16'h5555}, 0, 20, 32, rd, hb);
      begin
        for (int w = 0; w < 2000 && !wb_stb; w++) @(negedge wb_clk);
        chk("rst_stb_seen", wb_stb, 1);
        wb_rst = 1'b0;
        #1;
        chk("rst_mid_cyc", wb_cyc, 0);
        chk("rst_mid_stb", wb_stb, 0);
        chk("rst_mid_miso", spi_miso, 0);
        @(negedge wb_clk);
        wb_rst = 1'b1;
      end
    join
    ack_delay = 0;
    do_write(15'd0, 16'h0001, 20);
    do_read(15'd0, 16'h0001, 4);
    do_read(15'd9, 16'h0000, 4);

    repeat (10) @(negedge wb_clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
